// File: rtl/hcsr04_if.sv
// Trigger/echo link between a range-sensor master and an HC-SR04 responder,
// plus the responder's status strobes.
interface hcsr04_if;
  logic       trigger;
  logic [8:0] distance_cm;
  logic       no_target;
  logic       echo;
  logic       busy;
  logic       done;
  logic       trig_short;

  modport master (
    output trigger, distance_cm, no_target,
    input  echo, busy, done, trig_short
  );

  modport slave (
    input  trigger, distance_cm, no_target,
    output echo, busy, done, trig_short
  );
endinterface

// File: rtl/hcsr04_responder.sv
// HC-SR04 sensor model: qualifies a trigger pulse, waits a burst delay, then returns an
// echo whose width is distance_cm*CYCLES_PER_CM, or TIMEOUT_CYCLES for no/invalid target.
module hcsr04_responder #(
  parameter int TRIG_MIN_CYCLES    = 500,
  parameter int BURST_DELAY_CYCLES = 12500,
  parameter int CYCLES_PER_CM      = 2900,
  parameter int MAX_CM             = 400,
  parameter int TIMEOUT_CYCLES     = 1900000,
  parameter int HOLDOFF_CYCLES     = 500000
) (
  input  logic     clk,
  input  logic     rst,
  hcsr04_if.slave  bus
);

  localparam int MAX_BH  = (BURST_DELAY_CYCLES > HOLDOFF_CYCLES) ? BURST_DELAY_CYCLES : HOLDOFF_CYCLES;
  localparam int MAX_TC  = (TIMEOUT_CYCLES > CYCLES_PER_CM) ? TIMEOUT_CYCLES : CYCLES_PER_CM;
  localparam int MAX_ALL = (MAX_BH > MAX_TC) ? MAX_BH : MAX_TC;
  localparam int CW      = $clog2(MAX_ALL + 1);
  localparam int HW      = $clog2(TRIG_MIN_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, TRIG_HI, BURST, ECHO, HOLDOFF} state_t;

  state_t        state_r, state_n;
  logic          sync1_r, trig_s, trig_d_r;
  logic [HW-1:0] hi_cnt_r, hi_cnt_n;
  logic [CW-1:0] cnt_r, cnt_n;
  logic [CW-1:0] sub_lim_r, sub_lim_n;
  logic [8:0]    cm_cnt_r, cm_cnt_n;
  logic [8:0]    cm_lim_r, cm_lim_n;
  logic          echo_r, echo_n;
  logic          busy_r, busy_n;
  logic          done_r, done_n;
  logic          short_r, short_n;
  logic          rise_s, fall_s, timeout_s;

  assign rise_s    = trig_s & ~trig_d_r;
  assign fall_s    = ~trig_s & trig_d_r;
  assign timeout_s = bus.no_target || (bus.distance_cm == 9'd0) || (bus.distance_cm > 9'(MAX_CM));

  // Two-stage synchronizer for the asynchronous trigger, plus the edge-detect copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r  <= 1'b0;
      trig_s   <= 1'b0;
      trig_d_r <= 1'b0;
    end else begin
      sync1_r  <= bus.trigger;
      trig_s   <= sync1_r;
      trig_d_r <= trig_s;
    end
  end

  // Next-state and next-output logic for the measurement sequence.
  always_comb begin
    state_n   = state_r;
    hi_cnt_n  = hi_cnt_r;
    cnt_n     = cnt_r;
    sub_lim_n = sub_lim_r;
    cm_cnt_n  = cm_cnt_r;
    cm_lim_n  = cm_lim_r;
    echo_n    = echo_r;
    done_n    = 1'b0;
    short_n   = 1'b0;
    case (state_r)
      IDLE: begin
        if (rise_s) begin
          state_n  = TRIG_HI;
          hi_cnt_n = HW'(1);
        end else begin
          state_n  = IDLE;
        end
      end
      TRIG_HI: begin
        if (fall_s) begin
          if (hi_cnt_r >= HW'(TRIG_MIN_CYCLES)) begin
            // Echo length is held as (cm limit, sub limit) so ECHO needs no multiplier.
            state_n   = BURST;
            cnt_n     = '0;
            cm_cnt_n  = 9'd0;
            cm_lim_n  = timeout_s ? 9'd0 : (bus.distance_cm - 9'd1);
            sub_lim_n = timeout_s ? CW'(TIMEOUT_CYCLES - 1) : CW'(CYCLES_PER_CM - 1);
          end else begin
            short_n   = 1'b1;
            state_n   = IDLE;
          end
        end else if (hi_cnt_r < HW'(TRIG_MIN_CYCLES)) begin
          hi_cnt_n = hi_cnt_r + HW'(1);
        end else begin
          hi_cnt_n = hi_cnt_r;
        end
      end
      BURST: begin
        if (cnt_r == CW'(BURST_DELAY_CYCLES - 1)) begin
          echo_n   = 1'b1;
          state_n  = ECHO;
          cnt_n    = '0;
          cm_cnt_n = 9'd0;
        end else begin
          cnt_n    = cnt_r + CW'(1);
        end
      end
      ECHO: begin
        if (cnt_r == sub_lim_r) begin
          cnt_n = '0;
          if (cm_cnt_r == cm_lim_r) begin
            echo_n  = 1'b0;
            done_n  = 1'b1;
            state_n = HOLDOFF;
          end else begin
            cm_cnt_n = cm_cnt_r + 9'd1;
          end
        end else begin
          cnt_n = cnt_r + CW'(1);
        end
      end
      HOLDOFF: begin
        if (cnt_r == CW'(HOLDOFF_CYCLES - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n   = cnt_r + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        echo_n  = 1'b0;
        cnt_n   = '0;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      hi_cnt_r  <= '0;
      cnt_r     <= '0;
      sub_lim_r <= '0;
      cm_cnt_r  <= 9'd0;
      cm_lim_r  <= 9'd0;
      echo_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      short_r   <= 1'b0;
    end else begin
      state_r   <= state_n;
      hi_cnt_r  <= hi_cnt_n;
      cnt_r     <= cnt_n;
      sub_lim_r <= sub_lim_n;
      cm_cnt_r  <= cm_cnt_n;
      cm_lim_r  <= cm_lim_n;
      echo_r    <= echo_n;
      busy_r    <= busy_n;
      done_r    <= done_n;
      short_r   <= short_n;
    end
  end

  assign bus.echo       = echo_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.trig_short = short_r;

endmodule
